voice_slot_scheduler: RTL
=========================

# voice_slot_scheduler

Voice allocator and per-frame slot sequencer for the shared synthesis datapath. It accepts note-on/note-off requests from the MIDI front end and maintains a table of NUM_VOICES voice entries. Once per 48 kHz audio frame it streams every entry, one slot per clock, to the time-multiplexed oscillator/mixer pipeline. It owns the frame counter and supersedes the free-running slot event generator.

## Interface
- NUM_VOICES, 36, number of voice slots per frame
- FRAME_CYCLES, 667, clocks per audio frame; the counter wraps at FRAME_CYCLES-1
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- note_valid  in  1  request present
- note_ready  out  1  request accepted when note_valid && note_ready
- note_on  in  1  1 = note-on, 0 = note-off
- note_num  in  7  MIDI note number
- note_vel  in  7  velocity; a note-on with velocity 0 is treated as a note-off
- slot_valid  out  1  slot descriptor valid this cycle
- slot_idx  out  6  voice index 0..NUM_VOICES-1
- slot_active  out  1  voice is sounding
- slot_note  out  7  note of the voice
- slot_vel  out  7  velocity of the voice
- frame_start  out  1  one-cycle pulse coincident with slot_idx==0
- voices_busy  out  6  count of active entries
- drop  out  1  one-cycle pulse when a note-on finds no voice to use

## Operation
- **Voice table.** NUM_VOICES entries, each {active, note, vel}, held in registers.
- **Frame counter.** Counts 0..FRAME_CYCLES-1, then wraps to 0.
- **Slot readout.** While count < NUM_VOICES, the slot output registers load table[count], slot_valid goes to 1 and slot_idx takes the value of count. Otherwise slot_valid is 0 and the other slot outputs hold their last value.
- **Request FSM states:**
  - IDLE: note_ready=1. An accepted request is latched, along with the search result for it, and the FSM moves to COMMIT.
  - COMMIT: note_ready=0. The table write is performed and the FSM returns to IDLE unconditionally.
- **Note-on search priority:**
  1. An active entry with the same note: retrigger by overwriting vel at that index.
  2. Otherwise the lowest-index free entry: write active=1, note, vel.
  3. Otherwise no entry is available: pulse drop in COMMIT and leave the table unchanged (default build).
- **Note-off search.** Clear active on the lowest-index active entry whose note matches. If nothing matches, the request is ignored and drop is not pulsed.
- **Busy count.** voices_busy updates in the same cycle as the table write: +1 on allocation, -1 on release, unchanged on retrigger or steal.

## Timing
- **Reset values.** All outputs 0, table cleared, count=0, FSM in IDLE.
- **Reset mid-operation.** A latched request is discarded and no partial write occurs.
- **First frame after reset.** The first clock edge after rst falls is the count=0 edge. From the following cycle, slot_valid is high for exactly NUM_VOICES consecutive cycles. frame_start rises with slot_idx=0 and repeats every FRAME_CYCLES cycles.
- **Request latency.** A request accepted on edge T is written on edge T+1. It is visible in slot readout for any count sampled on edge T+2 or later.
- **Throughput.** At most one request every 2 cycles.
- **Same-cycle read/write.** If the table is read and written at the same index in one cycle, readout returns the old value.
- **No stall.** Requests are accepted during the slot window; the readout is never paused.

## Configuration
- VOICE_STEAL_EN:
  - Defined: a note-on that finds no free or matching entry steals the entry at steal_ptr (6-bit, reset 0), overwrites it, and advances steal_ptr modulo NUM_VOICES. drop is never asserted.
  - Undefined: no steal_ptr exists and the drop behaviour above applies.

## Structure
- **Package synth_pkg** holds:
  - NUM_VOICES, FRAME_CYCLES and VOICE_IDX_W=6
  - voice_entry_t {active, note[6:0], vel[6:0]}
  - the request FSM state enum
- **Sub-module voice_alloc_search.** Combinational search: match index, first-free index, match_found and free_found flags, via priority encoders over the table.

## Test plan
1. **Reset and frame cadence.** Assert then release reset → all outputs 0 during reset. slot_idx steps 0..35 on consecutive cycles with slot_active=0, and frame_start pulses every 667 cycles.
2. **Single note-on.** Note-on 60, velocity 100 → accepted, voices_busy=1. The next frame shows slot_idx 0 with active=1, note 60, vel 100.
3. **Retrigger and allocation.** Note-on 60 vel 50 → index 0 vel becomes 50, busy stays 1. Then note-on 64 vel 80 → index 1 allocated, busy=2.
4. **Release paths.** Note-off 60 → index 0 becomes inactive. Note-on 64 vel 0 → index 1 becomes inactive, busy=0. Note-off 70 → no change, no drop.
5. **Table full.** Fill 36 distinct notes, then note-on 100:
   - macro off → one drop pulse, table unchanged, busy=36;
   - VOICE_STEAL_EN → index 0 holds note 100, and a further note-on 101 lands in index 1.
6. **Handshake and reset abort.** Hold note_valid high with new data every cycle → accept every second cycle. Assert rst during COMMIT → table empty and busy=0 after release.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared constants, voice table entry and request FSM state for the synthesis voice scheduler.
package synth_pkg;

    localparam int unsigned NUM_VOICES   = 36;
    localparam int unsigned FRAME_CYCLES = 667;
    localparam int unsigned VOICE_IDX_W  = 6;
    localparam int unsigned CNT_W        = 10;

    typedef struct packed {
        logic       active;
        logic [6:0] note;
        logic [6:0] vel;
    } voice_entry_t;

    typedef enum logic {
        ST_IDLE,
        ST_COMMIT
    } req_state_t;

endpackage

// File: rtl/voice_alloc_search.sv
// Combinational priority search over the voice table: lowest-index note match and lowest-index free entry.
module voice_alloc_search
    import synth_pkg::*;
(
    input  voice_entry_t           table_i [NUM_VOICES],
    input  logic [6:0]             note_i,
    output logic                   match_found_o,
    output logic [VOICE_IDX_W-1:0] match_idx_o,
    output logic                   free_found_o,
    output logic [VOICE_IDX_W-1:0] free_idx_o
);

    always_comb begin
        match_found_o = 1'b0;
        match_idx_o   = '0;
        free_found_o  = 1'b0;
        free_idx_o    = '0;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            if (!match_found_o && table_i[i].active && (table_i[i].note == note_i)) begin
                match_found_o = 1'b1;
                match_idx_o   = VOICE_IDX_W'(i);
            end
            if (!free_found_o && !table_i[i].active) begin
                free_found_o = 1'b1;
                free_idx_o   = VOICE_IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/voice_slot_scheduler.sv
// Voice allocator and per-frame slot sequencer feeding the time-multiplexed synthesis pipeline.
// Optional macro VOICE_STEAL_EN: round-robin voice stealing instead of dropping when the table is full.
module voice_slot_scheduler
    import synth_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   note_valid,
    output logic                   note_ready,
    input  logic                   note_on,
    input  logic [6:0]             note_num,
    input  logic [6:0]             note_vel,
    output logic                   slot_valid,
    output logic [VOICE_IDX_W-1:0] slot_idx,
    output logic                   slot_active,
    output logic [6:0]             slot_note,
    output logic [6:0]             slot_vel,
    output logic                   frame_start,
    output logic [VOICE_IDX_W-1:0] voices_busy,
    output logic                   drop
);

    req_state_t             state_q, state_d;
    voice_entry_t           table_q [NUM_VOICES];
    logic [CNT_W-1:0]       count_q;
    logic [VOICE_IDX_W-1:0] busy_q;

    logic                   req_on_q;
    logic [6:0]             req_note_q, req_vel_q;
    logic                   req_match_found_q, req_free_found_q;
    logic [VOICE_IDX_W-1:0] req_match_idx_q, req_free_idx_q;

    logic                   match_found, free_found;
    logic [VOICE_IDX_W-1:0] match_idx, free_idx;
    logic                   ready_c, accept;
    logic                   wr_en, busy_inc, busy_dec;
    logic [VOICE_IDX_W-1:0] wr_idx;
    voice_entry_t           wr_entry;
`ifdef VOICE_STEAL_EN
    logic [VOICE_IDX_W-1:0] steal_ptr_q;
    logic                   steal_adv;
`endif

    voice_alloc_search u_search (
        .table_i       (table_q),
        .note_i        (note_num),
        .match_found_o (match_found),
        .match_idx_o   (match_idx),
        .free_found_o  (free_found),
        .free_idx_o    (free_idx)
    );

    // Ready is gated by rst so every output reads 0 while reset is held.
    assign note_ready  = ready_c & ~rst;
    assign accept      = note_valid & note_ready;
    assign voices_busy = busy_q;

    always_comb begin
        state_d  = state_q;
        ready_c  = 1'b0;
        drop     = 1'b0;
        wr_en    = 1'b0;
        wr_idx   = '0;
        wr_entry = '0;
        busy_inc = 1'b0;
        busy_dec = 1'b0;
`ifdef VOICE_STEAL_EN
        steal_adv = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                ready_c = 1'b1;
                if (note_valid) state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
                if (req_on_q) begin
                    wr_entry = '{active: 1'b1, note: req_note_q, vel: req_vel_q};
                    if (req_match_found_q) begin
                        wr_en  = 1'b1;
                        wr_idx = req_match_idx_q;
                    end else if (req_free_found_q) begin
                        wr_en    = 1'b1;
                        wr_idx   = req_free_idx_q;
                        busy_inc = 1'b1;
                    end else begin
`ifdef VOICE_STEAL_EN
                        wr_en     = 1'b1;
                        wr_idx    = steal_ptr_q;
                        steal_adv = 1'b1;
`else
                        drop = 1'b1;
`endif
                    end
                end else if (req_match_found_q) begin
                    wr_en           = 1'b1;
                    wr_idx          = req_match_idx_q;
                    wr_entry        = table_q[req_match_idx_q];
                    wr_entry.active = 1'b0;
                    busy_dec        = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q           <= ST_IDLE;
            req_on_q          <= 1'b0;
            req_note_q        <= '0;
            req_vel_q         <= '0;
            req_match_found_q <= 1'b0;
            req_free_found_q  <= 1'b0;
            req_match_idx_q   <= '0;
            req_free_idx_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                req_on_q          <= note_on && (note_vel != '0);
                req_note_q        <= note_num;
                req_vel_q         <= note_vel;
                req_match_found_q <= match_found;
                req_free_found_q  <= free_found;
                req_match_idx_q   <= match_idx;
                req_free_idx_q    <= free_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_VOICES; i++) table_q[i] <= '0;
            busy_q <= '0;
        end else begin
            if (wr_en) table_q[wr_idx] <= wr_entry;
            if (busy_inc)      busy_q <= busy_q + 1'b1;
            else if (busy_dec) busy_q <= busy_q - 1'b1;
        end
    end

`ifdef VOICE_STEAL_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            steal_ptr_q <= '0;
        end else if (steal_adv) begin
            steal_ptr_q <= (steal_ptr_q == VOICE_IDX_W'(NUM_VOICES - 1)) ? '0 : steal_ptr_q + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q     <= '0;
            slot_valid  <= 1'b0;
            slot_idx    <= '0;
            slot_active <= 1'b0;
            slot_note   <= '0;
            slot_vel    <= '0;
            frame_start <= 1'b0;
        end else begin
            count_q <= (count_q == CNT_W'(FRAME_CYCLES - 1)) ? '0 : count_q + 1'b1;
            if (count_q < CNT_W'(NUM_VOICES)) begin
                slot_valid  <= 1'b1;
                slot_idx    <= count_q[VOICE_IDX_W-1:0];
                slot_active <= table_q[count_q[VOICE_IDX_W-1:0]].active;
                slot_note   <= table_q[count_q[VOICE_IDX_W-1:0]].note;
                slot_vel    <= table_q[count_q[VOICE_IDX_W-1:0]].vel;
                frame_start <= (count_q == '0);
            end else begin
                slot_valid  <= 1'b0;
                frame_start <= 1'b0;
            end
        end
    end

endmodule
